// File: rtl/ahb_client_arbiter.sv
// ahb_client_arbiter: two-client round-robin front end for a single AHB master.
// One transfer is latched per grant; the owner gets a one-cycle ack (with err on timeout).
module ahb_client_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_req,
  input  logic        c1_req,
  input  logic        c0_wr,
  input  logic        c1_wr,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c1_addr,
  input  logic [31:0] c0_wdata,
  input  logic [31:0] c1_wdata,
  output logic        c0_ack,
  output logic        c1_ack,
  output logic        c0_err,
  output logic        c1_err,
  output logic [31:0] rdata,
  output logic        re,
  output logic        we,
  output logic [31:0] mcu_raddr,
  output logic [31:0] mcu_waddr,
  output logic [31:0] buffer2_data,
  input  logic        read_complete,
  input  logic        write_complete,
  input  logic [31:0] greyscale_data,
  output logic        busy
);

  // The counter only ever reaches TIMEOUT-1 before the timeout fires.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t        state;
  logic          owner;
  logic          wr;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          grant;
  logic          sel_wr;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          done;

  // Round-robin pick, the picked client's fields, and the completion matching the latched type.
  always_comb begin
    grant = 1'b0;
    if (c0_req && c1_req) begin
      grant = ~last_grant;
    end else begin
      grant = c1_req;
    end
    sel_wr    = grant ? c1_wr    : c0_wr;
    sel_addr  = grant ? c1_addr  : c0_addr;
    sel_wdata = grant ? c1_wdata : c0_wdata;
    done      = wr ? write_complete : read_complete;
  end

  // Transfer sequencer; every output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      wr           <= 1'b0;
      last_grant   <= 1'b1;
      cnt          <= '0;
      c0_ack       <= 1'b0;
      c1_ack       <= 1'b0;
      c0_err       <= 1'b0;
      c1_err       <= 1'b0;
      rdata        <= 32'h0;
      re           <= 1'b0;
      we           <= 1'b0;
      mcu_raddr    <= 32'h0;
      mcu_waddr    <= 32'h0;
      buffer2_data <= 32'h0;
      busy         <= 1'b0;
    end else begin
      re     <= 1'b0;
      we     <= 1'b0;
      c0_ack <= 1'b0;
      c1_ack <= 1'b0;
      c0_err <= 1'b0;
      c1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (c0_req || c1_req) begin
            owner        <= grant;
            wr           <= sel_wr;
            mcu_raddr    <= sel_addr;
            mcu_waddr    <= sel_addr;
            buffer2_data <= sel_wdata;
            re           <= ~sel_wr;
            we           <= sel_wr;
            busy         <= 1'b1;
            state        <= ISSUE;
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A completion arriving on the last counted cycle still wins over the timeout.
          if (done) begin
            if (!wr) begin
              rdata <= greyscale_data;
            end
            c0_ack <= ~owner;
            c1_ack <= owner;
            state  <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            c0_ack <= ~owner;
            c1_ack <= owner;
            c0_err <= ~owner;
            c1_err <= owner;
            state  <= DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          last_grant <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        DRAIN: begin
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
